uart_rx_frame: RTL and testbench

- Parametrised successor to the team's fixed 8N1 UART receiver.
- Handles configurable data width, parity and stop-bit count.
- Uses 3-sample majority voting per bit, rejects start-bit glitches, and reports parity and framing errors.
- Sits between the board RX pin and the command/pixel-stream parser; one instance per serial link.

---
 rtl/uart_rx_frame_if.sv | 23 ++
 rtl/uart_rx_frame.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_frame_if.sv
// Serial-line side of uart_rx_frame: the RX pin plus the received word and status flags.
// The master modport is the receiver; the slave modport is whoever drives the pin and consumes frames.
interface uart_rx_frame_if #(
    parameter int data_bits = 8
);
    logic                 rx_serial_in;
    logic                 rx_dv_out;
    logic [data_bits-1:0] rx_out;
    logic                 parity_err_out;
    logic                 frame_err_out;
    logic                 busy_out;
    logic                 break_out;

    modport master (
        input  rx_serial_in,
        output rx_dv_out, rx_out, parity_err_out, frame_err_out, busy_out, break_out
    );

    modport slave (
        output rx_serial_in,
        input  rx_dv_out, rx_out, parity_err_out, frame_err_out, busy_out, break_out
    );
endinterface

// File: rtl/uart_rx_frame.sv
// UART receiver: configurable data/parity/stop bits, 3-sample majority vote, glitch-rejecting start; UART_RX_BREAK_DETECT_EN adds break_out.
// rx_dv_out pulses one clk after the last stop-bit centre sample; no backpressure, each frame is presented once.
module uart_rx_frame #(
    parameter int clk_per_bit = 87,
    parameter int data_bits   = 8,
    parameter int parity_mode = 0,
    parameter int stop_bits   = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_rx_frame_if.master rx_if
);
    localparam int CW = $clog2(clk_per_bit);
    localparam int IW = $clog2(data_bits);
    localparam logic [CW-1:0] MID       = CW'((clk_per_bit - 1) / 2);
    localparam logic [CW-1:0] LAST      = CW'(clk_per_bit - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(data_bits - 1);
    localparam logic          LAST_STOP = (stop_bits == 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE, WAIT_HIGH} state_t;

    state_t               state, state_n;
    logic                 sync1, rxs;
    logic [1:0]           samp;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        idx, idx_n;
    logic                 sidx, sidx_n;
    logic [data_bits-1:0] data_q, data_n;
    logic                 par_err_q, par_err_n;
    logic                 fe_acc, fe_acc_n;
    logic                 perr_out, perr_out_n;
    logic                 ferr_out, ferr_out_n;
    logic                 vote, bit_end;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                 par_bit_q, par_bit_n;
    logic                 brk_q, brk_n;
`endif

    // samp holds rxs from the two previous cycles, so the vote at a decision
    // count covers that count and the two counts before it.
    assign vote    = (samp[1] & samp[0]) | (samp[1] & rxs) | (samp[0] & rxs);
    assign bit_end = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            samp  <= 2'b11;
        end else begin
            sync1 <= rx_if.rx_serial_in;
            rxs   <= sync1;
            samp  <= {samp[0], rxs};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sidx      <= 1'b0;
            data_q    <= '0;
            par_err_q <= 1'b0;
            fe_acc    <= 1'b0;
            perr_out  <= 1'b0;
            ferr_out  <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            par_bit_q <= 1'b0;
            brk_q     <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            sidx      <= sidx_n;
            data_q    <= data_n;
            par_err_q <= par_err_n;
            fe_acc    <= fe_acc_n;
            perr_out  <= perr_out_n;
            ferr_out  <= ferr_out_n;
`ifdef UART_RX_BREAK_DETECT_EN
            par_bit_q <= par_bit_n;
            brk_q     <= brk_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        idx_n      = idx;
        sidx_n     = sidx;
        data_n     = data_q;
        par_err_n  = par_err_q;
        fe_acc_n   = fe_acc;
        perr_out_n = perr_out;
        ferr_out_n = ferr_out;
`ifdef UART_RX_BREAK_DETECT_EN
        par_bit_n  = par_bit_q;
        brk_n      = brk_q;
`endif
        case (state)
            IDLE: begin
                cnt_n  = '0;
                idx_n  = '0;
                sidx_n = 1'b0;
                if (!rxs) begin
                    state_n   = START;
                    par_err_n = 1'b0;
                    fe_acc_n  = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
                    par_bit_n = 1'b0;
`endif
                end
            end
            START: begin
                if (cnt == MID) begin
                    cnt_n   = '0;
                    state_n = vote ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_n       = '0;
                    data_n[idx] = vote;
                    if (idx == LAST_IDX) begin
                        idx_n   = '0;
                        state_n = (parity_mode != 0) ? PARITY : STOP;
                    end else begin
                        idx_n = idx + IW'(1);
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            PARITY: begin
                if (bit_end) begin
                    cnt_n     = '0;
                    par_err_n = (((^data_q) ^ vote) != (parity_mode == 2));
`ifdef UART_RX_BREAK_DETECT_EN
                    par_bit_n = vote;
`endif
                    state_n   = STOP;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (!vote) fe_acc_n = 1'b1;
                    if (sidx == LAST_STOP) begin
                        // Flags are loaded on entry to DONE so they are valid alongside rx_dv_out.
                        state_n    = DONE;
                        perr_out_n = par_err_q;
                        ferr_out_n = fe_acc | ~vote;
`ifdef UART_RX_BREAK_DETECT_EN
                        brk_n = (fe_acc | ~vote) && (data_q == '0) && !par_bit_q;
`endif
                    end else begin
                        sidx_n = sidx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DONE: begin
                state_n = ferr_out ? WAIT_HIGH : IDLE;
            end
            WAIT_HIGH: begin
                if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign rx_if.rx_dv_out      = (state == DONE);
    assign rx_if.rx_out         = data_q;
    assign rx_if.parity_err_out = perr_out;
    assign rx_if.frame_err_out  = ferr_out;
    assign rx_if.busy_out       = (state != IDLE);
`ifdef UART_RX_BREAK_DETECT_EN
    assign rx_if.break_out      = brk_q && (state == DONE);
`else
    assign rx_if.break_out      = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: three instances (8N1, 7E1, 8N2) at 16 clk per bit.
`timescale 1ns/1ps
module tb_uart_rx_frame;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] line;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_frame_if #(.data_bits(8)) ifa ();
    uart_rx_frame_if #(.data_bits(7)) ifb ();
    uart_rx_frame_if #(.data_bits(8)) ifc ();
    assign ifa.rx_serial_in = line[0];
    assign ifb.rx_serial_in = line[1];
    assign ifc.rx_serial_in = line[2];

    uart_rx_frame #(.clk_per_bit(16), .data_bits(8), .parity_mode(0), .stop_bits(1))
        dut_a (.clk(clk), .rst_n(rst_n), .rx_if(ifa.master));
    uart_rx_frame #(.clk_per_bit(16), .data_bits(7), .parity_mode(1), .stop_bits(1))
        dut_b (.clk(clk), .rst_n(rst_n), .rx_if(ifb.master));
    uart_rx_frame #(.clk_per_bit(16), .data_bits(8), .parity_mode(0), .stop_bits(2))
        dut_c (.clk(clk), .rst_n(rst_n), .rx_if(ifc.master));

    // Frame capture on every rx_dv_out pulse, sampled at negedge.
    int         dv_cnt [3];
    int         dv_cyc [3];
    logic [8:0] cap_dat [3];
    logic       cap_pe [3];
    logic       cap_fe [3];
    logic       cap_brk [3];
    int         brk_cnt = 0;

    always @(negedge clk) begin
        if (ifa.rx_dv_out) begin
            dv_cnt[0]++; dv_cyc[0] = cyc; cap_dat[0] = 9'(ifa.rx_out);
            cap_pe[0] = ifa.parity_err_out; cap_fe[0] = ifa.frame_err_out; cap_brk[0] = ifa.break_out;
        end
        if (ifb.rx_dv_out) begin
            dv_cnt[1]++; dv_cyc[1] = cyc; cap_dat[1] = 9'(ifb.rx_out);
            cap_pe[1] = ifb.parity_err_out; cap_fe[1] = ifb.frame_err_out; cap_brk[1] = ifb.break_out;
        end
        if (ifc.rx_dv_out) begin
            dv_cnt[2]++; dv_cyc[2] = cyc; cap_dat[2] = 9'(ifc.rx_out);
            cap_pe[2] = ifc.parity_err_out; cap_fe[2] = ifc.frame_err_out; cap_brk[2] = ifc.break_out;
        end
        if (ifa.break_out || ifb.break_out || ifc.break_out) brk_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic v, input int n);
        line[k] = v;
        idle(n);
    endtask

    task automatic send(input int k, input logic [8:0] d, input int nb, input bit par, input logic pb,
                        input logic s1, input logic s2, input int ns, output int t0);
        t0 = cyc;
        drive(k, 1'b0, 16);
        for (int i = 0; i < nb; i++) drive(k, d[i], 16);
        if (par) drive(k, pb, 16);
        drive(k, s1, 16);
        if (ns == 2) drive(k, s2, 16);
        line[k] = 1'b1;
    endtask

    logic exp_brk;
    int   t0, base, busy_cycles;

    initial begin
`ifdef UART_RX_BREAK_DETECT_EN
        exp_brk = 1'b1;
`else
        exp_brk = 1'b0;
`endif
        rst_n = 1'b0;
        line  = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dv",   32'(ifa.rx_dv_out), 0);
        check("rst_data", 32'(ifa.rx_out), 0);
        check("rst_pe",   32'(ifa.parity_err_out), 0);
        check("rst_fe",   32'(ifa.frame_err_out), 0);
        check("rst_busy", 32'(ifa.busy_out), 0);
        check("rst_brk",  32'(ifa.break_out), 0);
        check("rst_busy_b", 32'(ifb.busy_out), 0);
        check("rst_busy_c", 32'(ifc.busy_out), 0);
        rst_n = 1'b1;
        idle(10);

        // 8N1 0xA5: start edge at t0, 2 sync + 1 detect + 8 start + 9*16 bits -> DONE at t0+155.
        base = dv_cnt[0];
        send(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, t0);
        idle(8);
        check("a5_dv_count", 32'(dv_cnt[0] - base), 1);
        check("a5_data",     32'(cap_dat[0]), 32'h0A5);
        check("a5_pe",       32'(cap_pe[0]), 0);
        check("a5_fe",       32'(cap_fe[0]), 0);
        check("a5_latency",  32'(dv_cyc[0] - t0), 155);
        check("a5_brk",      32'(cap_brk[0]), 0);

        // 7E1 0x41 has two ones, so the correct even parity bit is 0.
        base = dv_cnt[1];
        send(1, 9'h041, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1, t0);
        idle(8);
        check("p1_dv_count", 32'(dv_cnt[1] - base), 1);
        check("p1_data",     32'(cap_dat[1]), 32'h41);
        check("p1_pe",       32'(cap_pe[1]), 1);
        check("p1_fe",       32'(cap_fe[1]), 0);
        send(1, 9'h041, 7, 1'b1, 1'b0, 1'b1, 1'b1, 1, t0);
        idle(8);
        check("p0_dv_count", 32'(dv_cnt[1] - base), 2);
        check("p0_data",     32'(cap_dat[1]), 32'h41);
        check("p0_pe",       32'(cap_pe[1]), 0);

        // 4-clk glitch: START holds from edge 3 to edge 10, vote rejects at mid=7.
        base = dv_cnt[0];
        busy_cycles = 0;
        line[0] = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (i == 4) line[0] = 1'b1;
            #2;
            if (ifa.busy_out) busy_cycles++;
        end
        idle(1);
        check("glitch_busy_cycles", 32'(busy_cycles), 8);
        check("glitch_no_dv",       32'(dv_cnt[0] - base), 0);
        send(0, 9'h03C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, t0);
        idle(8);
        check("3c_dv_count", 32'(dv_cnt[0] - base), 1);
        check("3c_data",     32'(cap_dat[0]), 32'h03C);
        check("3c_fe",       32'(cap_fe[0]), 0);

        // 8N2: clean frame, then second stop bit low with the line held low afterwards.
        base = dv_cnt[2];
        send(2, 9'h0C3, 8, 1'b0, 1'b0, 1'b1, 1'b1, 2, t0);
        idle(8);
        check("c3_data", 32'(cap_dat[2]), 32'h0C3);
        check("c3_fe",   32'(cap_fe[2]), 0);
        send(2, 9'h096, 8, 1'b0, 1'b0, 1'b1, 1'b0, 2, t0);
        line[2] = 1'b0;
        drive(2, 1'b0, 40);
        check("s2_dv_count", 32'(dv_cnt[2] - base), 2);
        check("s2_data",     32'(cap_dat[2]), 32'h096);
        check("s2_fe",       32'(cap_fe[2]), 1);
        check("s2_pe",       32'(cap_pe[2]), 0);
        check("s2_brk",      32'(cap_brk[2]), 0);
        check("s2_busy_low", 32'(ifc.busy_out), 1);
        drive(2, 1'b1, 6);
        check("s2_busy_released", 32'(ifc.busy_out), 0);

        // Break: line low for 12 bit times on the 8N1 instance.
        base = dv_cnt[0];
        drive(0, 1'b0, 180);
        check("brk_dv_count", 32'(dv_cnt[0] - base), 1);
        check("brk_data",     32'(cap_dat[0]), 0);
        check("brk_fe",       32'(cap_fe[0]), 1);
        check("brk_flag",     32'(cap_brk[0]), 32'(exp_brk));
        check("brk_busy_low", 32'(ifa.busy_out), 1);
        drive(0, 1'b0, 12);
        drive(0, 1'b1, 6);
        check("brk_busy_released", 32'(ifa.busy_out), 0);
        check("brk_no_retrigger",  32'(dv_cnt[0] - base), 1);
        check("brk_pulse_count",   32'(brk_cnt), 32'(exp_brk));

        // Reset during data bit 4 of 0xFF; frame_err_out still holds 1 from the break.
        drive(0, 1'b0, 16);
        for (int i = 0; i < 4; i++) drive(0, 1'b1, 16);
        repeat (8) @(posedge clk);
        #2;
        check("pre_rst_busy", 32'(ifa.busy_out), 1);
        check("pre_rst_fe",   32'(ifa.frame_err_out), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(ifa.busy_out), 0);
        check("mid_rst_dv",   32'(ifa.rx_dv_out), 0);
        check("mid_rst_data", 32'(ifa.rx_out), 0);
        check("mid_rst_fe",   32'(ifa.frame_err_out), 0);
        check("mid_rst_pe",   32'(ifa.parity_err_out), 0);
        check("mid_rst_brk",  32'(ifa.break_out), 0);
        line[0] = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(20);
        base = dv_cnt[0];
        send(0, 9'h05A, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, t0);
        idle(8);
        check("5a_dv_count", 32'(dv_cnt[0] - base), 1);
        check("5a_data",     32'(cap_dat[0]), 32'h05A);
        check("5a_fe",       32'(cap_fe[0]), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
